// File: rtl/rv32_inst_encoder.sv
// RV32I field-to-word encoder with a 2-entry output FIFO.
// Optional ENC_CHECK_EN enables field checking and the err code.
module rv32_inst_encoder #(
  parameter int WIDTH    = 32,
  parameter int INST_MAX = 32,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          itype,
  input  logic [6:0]          opcode,
  input  logic [9:0]          fun,
  input  logic [WIDTH-1:0]    d0imm,
  input  logic [WIDTH-1:0]    s1,
  input  logic [WIDTH-1:0]    s2imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INST_MAX-1:0] inst,
  output logic [2:0]          err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd, rs1, rs2;
  logic [INST_MAX-1:0] word;
  logic [INST_MAX-1:0] wdata;
  logic [2:0] werr;
  logic unused_bits;

  assign f3  = fun[9:7];
  assign f7  = fun[6:0];
  assign rd  = d0imm[4:0];
  assign rs1 = s1[4:0];
  assign rs2 = s2imm[4:0];
  assign unused_bits = ^{d0imm, s1, s2imm};

  // Pack the fields according to the selected format
  always_comb begin
    word = '0;
    case (1'b1)
      itype[5]: word = {f7, rs2, rs1, f3, rd, opcode};
      itype[4]: word = {s2imm[11:0], rs1, f3, rd, opcode};
      itype[3]: word = {d0imm[11:5], rs2, rs1, f3,
                        d0imm[4:0], opcode};
      itype[2]: word = {d0imm[12], d0imm[10:5], rs2, rs1, f3,
                        d0imm[4:1], d0imm[11], opcode};
      itype[1]: word = {s2imm[31:12], rd, opcode};
      itype[0]: word = {s2imm[20], s2imm[10:1], s2imm[11],
                        s2imm[19:12], rd, opcode};
      default:  word = '0;
    endcase
  end

`ifdef ENC_CHECK_EN
  function automatic logic fits(input logic [WIDTH-1:0] v,
                                input int n);
    logic [WIDTH-1:0] t;
    t = WIDTH'($signed(v) >>> (n - 1));
    return (t == '0) || (t == '1);
  endfunction

  function automatic logic hi(input logic [WIDTH-1:0] v);
    return |v[WIDTH-1:5];
  endfunction

  logic opc_ok, reg_bad, imm_bad, b0_bad;

  // Per-format checks, then the first failing one sets err
  always_comb begin
    opc_ok  = 1'b0;
    reg_bad = 1'b0;
    imm_bad = 1'b0;
    b0_bad  = 1'b0;
    werr    = 3'd0;
    case (1'b1)
      itype[5]: begin
        opc_ok  = opcode == 7'h33;
        reg_bad = hi(d0imm) | hi(s1) | hi(s2imm);
      end
      itype[4]: begin
        opc_ok  = (opcode == 7'h13) || (opcode == 7'h03) ||
                  (opcode == 7'h67) || (opcode == 7'h73);
        reg_bad = hi(d0imm) | hi(s1);
        imm_bad = !fits(s2imm, 12);
      end
      itype[3]: begin
        opc_ok  = opcode == 7'h23;
        reg_bad = hi(s1) | hi(s2imm);
        imm_bad = !fits(d0imm, 12);
      end
      itype[2]: begin
        opc_ok  = opcode == 7'h63;
        reg_bad = hi(s1) | hi(s2imm);
        imm_bad = !fits(d0imm, 13);
        b0_bad  = d0imm[0];
      end
      itype[1]: begin
        opc_ok  = (opcode == 7'h37) || (opcode == 7'h17);
        reg_bad = hi(d0imm);
        imm_bad = |s2imm[11:0];
      end
      itype[0]: begin
        opc_ok  = opcode == 7'h6F;
        reg_bad = hi(d0imm);
        imm_bad = !fits(s2imm, 21);
        b0_bad  = s2imm[0];
      end
      default: opc_ok = 1'b0;
    endcase
    if (!$onehot(itype)) werr = 3'd1;
    else if (!opc_ok)    werr = 3'd2;
    else if (reg_bad)    werr = 3'd3;
    else if (imm_bad)    werr = 3'd4;
    else if (b0_bad)     werr = 3'd5;
  end

  assign wdata = (werr != 3'd0) ? '0 : word;
`else
  assign werr  = 3'd0;
  assign wdata = word;
`endif

  logic [INST_MAX-1:0] inst_q [2];
  logic [2:0]          err_q  [2];
  logic                wptr_q, rptr_q;
  occ_e                cnt_q, cnt_d;
  logic                push, pop;

  assign in_ready  = cnt_q != FULL;
  assign out_valid = cnt_q != EMPTY;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign inst      = inst_q[rptr_q];
  assign err       = err_q[rptr_q];

  // Occupancy next state from push/pop
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = occ_e'(cnt_q + 2'd1);
      2'b01:   cnt_d = occ_e'(cnt_q - 2'd1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Occupancy register and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= EMPTY;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
    end
  end

  // Storage; cleared on reset so inst/err read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        inst_q[i] <= '0;
        err_q[i]  <= 3'd0;
      end
    end else if (push) begin
      inst_q[wptr_q] <= wdata;
      err_q[wptr_q]  <= werr;
    end
  end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Bench for rv32_inst_encoder: vector table plus scoreboard.
// Expectations follow whether ENC_CHECK_EN is defined.
module tb_rv32_inst_encoder;

`ifdef ENC_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [5:0]  itype;
  logic [6:0]  opcode;
  logic [9:0]  fun;
  logic [31:0] d0imm, s1, s2imm;
  logic        out_valid, out_ready;
  logic [31:0] inst;
  logic [2:0]  err;

  rv32_inst_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .itype(itype), .opcode(opcode), .fun(fun),
    .d0imm(d0imm), .s1(s1), .s2imm(s2imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst(inst), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  it;
    logic [6:0]  op;
    logic [9:0]  fn;
    logic [31:0] d0, r1, s2;
    logic [31:0] ei;
    logic [2:0]  ee;
    bit          ci;
  } vec_t;

  typedef struct {
    logic [31:0] i;
    logic [2:0]  e;
    bit          c;
  } sb_t;

  vec_t tv [13];
  sb_t  sb [$];
  sb_t  cur;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [5:0] it, input logic [6:0] op,
    input logic [9:0] fn, input logic [31:0] d0,
    input logic [31:0] r1, input logic [31:0] s2,
    input logic [31:0] ok_i, input logic [2:0] e,
    input bit ci);
    vec_t v;
    v.it = it; v.op = op; v.fn = fn;
    v.d0 = d0; v.r1 = r1; v.s2 = s2;
    v.ei = (CK && e != 3'd0) ? 32'h0 : ok_i;
    v.ee = CK ? e : 3'd0;
    v.ci = ci;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    itype = v.it; opcode = v.op; fun = v.fn;
    d0imm = v.d0; s1 = v.r1; s2imm = v.s2;
    cur.i = v.ei; cur.e = v.ee; cur.c = v.ci;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    drive(v);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Scoreboard: compare on pop, record on push
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("err", {29'd0, err}, {29'd0, e.e});
          if (e.c) chk("inst", inst, e.i);
        end
      end
      if (in_valid && in_ready) sb.push_back(cur);
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    itype = '0; opcode = '0; fun = '0;
    d0imm = '0; s1 = '0; s2imm = '0;
    cur.i = '0; cur.e = '0; cur.c = 1'b0;

    tv[0]  = mk(6'b100000, 7'h33, 10'h000, 3, 1, 2,
                32'h002081B3, 0, 1);
    tv[1]  = mk(6'b010000, 7'h13, 10'h000, 1, 0, 5,
                32'h00500093, 0, 1);
    tv[2]  = mk(6'b000010, 7'h37, 10'h000, 5, 0, 32'h12345000,
                32'h123452B7, 0, 1);
    tv[3]  = mk(6'b000100, 7'h63, 10'h000, 32'hFFFFFFFC, 1, 2,
                32'hFE208EE3, 0, 1);
    tv[4]  = mk(6'b001000, 7'h23, 10'h100, 8, 1, 2,
                32'h0020A423, 0, 1);
    tv[5]  = mk(6'b000001, 7'h6F, 10'h000, 1, 0, 8,
                32'h008000EF, 0, 1);
    tv[6]  = mk(6'b100000, 7'h33, 10'h020, 3, 1, 2,
                32'h402081B3, 0, 1);
    tv[7]  = mk(6'b010000, 7'h13, 10'h000, 1, 0, 32'h800,
                32'h80000093, 4, 1);
    tv[8]  = mk(6'b110000, 7'h33, 10'h000, 3, 1, 2,
                32'h0, 1, CK);
    tv[9]  = mk(6'b000001, 7'h6F, 10'h000, 1, 0, 3,
                32'h002000EF, 5, 1);
    tv[10] = mk(6'b100000, 7'h13, 10'h000, 3, 1, 2,
                32'h00208193, 2, 1);
    tv[11] = mk(6'b100000, 7'h33, 10'h000, 3, 32, 2,
                32'h002001B3, 3, 1);
    tv[12] = mk(6'b000100, 7'h63, 10'h000, 1, 1, 2,
                32'h00208063, 5, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_inst", inst, 32'd0);
    chk("rst_err", {29'd0, err}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // One-cycle latency
    @(posedge clk); #1 drive(tv[0]);
    @(negedge clk);
    chk("lat_pre_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_post_valid", {31'd0, out_valid}, 32'd1);
    repeat (2) @(negedge clk);

    // Table, streaming with consumer always ready
    for (int i = 0; i < 13; i++) send(tv[i]);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Backpressure: 2 accepts then full
    out_ready = 1'b0;
    send(tv[1]);
    send(tv[2]);
    @(posedge clk); #1 drive(tv[3]);
    @(negedge clk);
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("bp_still_full", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_inst", inst, 32'h00500093);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_passthru", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_third_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_drained", sb.size(), 32'd0);

    // Reset while holding two entries
    out_ready = 1'b0;
    send(tv[4]);
    send(tv[5]);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst_inst", inst, 32'd0);
    end
    send(tv[6]);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("final_empty", sb.size(), 32'd0);
    chk("final_valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
